// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the run-to-count LFSR sequencer.
package lfsr_pkg;

  localparam int         LFSR_WIDTH   = 9;
  localparam int         LFSR_CNT_W   = 16;
  localparam logic [8:0] TAPS_9       = 9'h110;
  localparam logic [8:0] SEED_NONZERO = 9'h001;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/lfsr_step_cnt.sv
// Loadable down-counter with decrement enable; flags zero and one so the
// sequencer can detect the final shift without a second comparator.
module lfsr_step_cnt
  import lfsr_pkg::*;
#(
  parameter int CNT_W = LFSR_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             one
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == CNT_W'(1));

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for a shift/load register: loads a seed, runs nsteps LFSR shifts
// (pausable with hold), then reports the final register value with done.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_9),
  parameter int               CNT_W = LFSR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] nsteps,
  input  logic             hold,
  input  logic [WIDTH-1:0] q,
  output logic             load,
  output logic             shift,
  output logic [WIDTH-1:0] d,
  output logic             d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_seed
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] seed_r;
  logic [WIDTH-1:0] result_r;
  logic             accept;
  logic             cnt_zero;
  logic             cnt_one;
  logic [CNT_W-1:0] cnt;

  assign accept = (state == IDLE) && start;

  lfsr_step_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .load  (accept),
    .value (nsteps),
    .dec   (shift),
    .count (cnt),
    .zero  (cnt_zero),
    .one   (cnt_one)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // An all-zero seed would lock the LFSR, so it is replaced and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_r    <= '0;
      zero_seed <= 1'b0;
      result_r  <= '0;
    end else begin
      if (accept) begin
        if (seed == '0) begin
          seed_r    <= WIDTH'(SEED_NONZERO);
          zero_seed <= 1'b1;
        end else begin
          seed_r    <= seed;
          zero_seed <= 1'b0;
        end
      end
      if (state == DONE) begin
        result_r <= q;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    d        = '0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        load     = 1'b1;
        d        = seed_r;
        state_nx = cnt_zero ? DONE : RUN;
      end
      RUN: begin
        shift = !hold;
        if (!hold && cnt_one) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign d_in = ^(q & TAPS);
  // In DONE the register already holds the post-shift value, so q is
  // forwarded directly to make result valid alongside done.
  assign result = (state == DONE) ? q : result_r;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench: sequencer plus a behavioural shift/load register,
// checked every cycle against a run-level reference model.
module tb_lfsr_seq_ctrl;

  localparam int W  = 9;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [CW-1:0] nsteps = '0;
  logic [W-1:0]  q, d, result;
  logic          load, shift, d_in, busy, done, zero_seed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .nsteps    (nsteps),
    .hold      (hold),
    .q         (q),
    .load      (load),
    .shift     (shift),
    .d         (d),
    .d_in      (d_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero_seed (zero_seed)
  );

  // Shift/load register the sequencer drives, with q looped back.
  logic [W-1:0] q_reg = '0;
  always @(posedge clk) begin
    if (load)       q_reg <= d;
    else if (shift) q_reg <= {q_reg[W-2:0], d_in};
  end
  assign q = q_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    n_cmp++;
    if (act === bad) begin
      n_bad++;
      $display("FAIL %s: got %0h, required anything but %0h", name, act, bad);
    end
  endtask

  // x^9 + x^5 + 1 stepped n times.
  function automatic logic [8:0] lfsr_run(input logic [8:0] s, input int n);
    logic [8:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[7:0], v[8] ^ v[4]};
    return v;
  endfunction

  // Reference model: one accepted run at a time, described by its load
  // cycle, shifts completed so far and the precomputed final value.
  bit         m_active = 1'b0;
  int         cyc = 0;
  int         m_t = 0;
  int         m_n = 0;
  int         m_k = 0;
  logic [8:0] m_seed = '0;
  logic [8:0] m_res = '0;
  logic [8:0] m_last = '0;
  bit         m_zs = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_last   = '0;
      m_zs     = 1'b0;
    end else begin
      bit was;
      was = m_active;
      if (was) begin
        if (cyc == m_t + 1) begin
        end else if (m_k < m_n) begin
          if (!hold) m_k++;
        end else begin
          m_active = 1'b0;
          m_last   = m_res;
        end
      end
      if (!was && start) begin
        m_active = 1'b1;
        m_t      = cyc;
        m_n      = int'(nsteps);
        m_k      = 0;
        m_zs     = (seed == '0);
        m_seed   = (seed == '0) ? 9'h001 : seed;
        m_res    = lfsr_run(m_seed, m_n);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit e_load, e_run, e_done;
    e_load = m_active && (cyc == m_t + 1);
    e_run  = m_active && !e_load && (m_k < m_n);
    e_done = m_active && !e_load && (m_k == m_n);
    check("cmp_load",   load,  e_load);
    check("cmp_shift",  shift, e_run && !hold);
    check("cmp_d",      d,     e_load ? m_seed : 9'h000);
    check("cmp_d_in",   d_in,  q[8] ^ q[4]);
    check("cmp_busy",   busy,  m_active);
    check("cmp_done",   done,  e_done);
    check("cmp_result", result, e_done ? m_res : m_last);
    check("cmp_zero_seed", zero_seed, m_zs);
  end

  // Called #1 after a clock edge with the sequencer idle.
  task automatic run(input logic [8:0] s, input int n, input int hs, input int hl,
                     input logic [8:0] exp_d, input logic [8:0] exp_res,
                     input int exp_lat, input bit exp_zs, input bit want_ne);
    bit got;
    start  = 1'b1;
    seed   = s;
    nsteps = CW'(n);
    hold   = 1'b0;
    @(posedge clk);
    #1;
    start  = 1'b0;
    seed   = W'($urandom);
    nsteps = CW'($urandom);
    got    = 1'b0;
    for (int c = 1; c <= exp_lat + 20 && !got; c++) begin
      hold = (c >= hs) && (c < hs + hl);
      @(negedge clk);
      if (c == 1) begin
        check("run_load_pulse", load, 1'b1);
        check("run_load_d", d, exp_d);
      end
      if (done) begin
        got = 1'b1;
        if (want_ne) check_ne("run_result_ne", result, 9'h001);
        else         check("run_result", result, exp_res);
        check("run_latency", c, exp_lat);
        check("run_zero_seed", zero_seed, exp_zs);
      end
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    if (!got) check("run_done_timeout", 0, 1);
  endtask

  initial begin
    int dones;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 9'h000);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    run(9'h001, 5,   0, 0, 9'h001, 9'h021, 7,   1'b0, 1'b0);
    run(9'h0A5, 0,   0, 0, 9'h0A5, 9'h0A5, 2,   1'b0, 1'b0);
    run(9'h000, 5,   0, 0, 9'h001, 9'h021, 7,   1'b1, 1'b0);
    run(9'h001, 5,   4, 3, 9'h001, 9'h021, 10,  1'b0, 1'b0);
    run(9'h001, 511, 0, 0, 9'h001, 9'h001, 513, 1'b0, 1'b0);
    run(9'h001, 510, 0, 0, 9'h001, 9'h000, 512, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a long run.
    start = 1'b1; seed = 9'h001; nsteps = 16'd100;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_load",  load,  1'b0);
    check("abort_shift", shift, 1'b0);
    check("abort_busy",  busy,  1'b0);
    check("abort_done",  done,  1'b0);
    check("abort_d",     d,     9'h000);
    check("abort_result", result, 9'h000);
    check("abort_zero_seed", zero_seed, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    run(9'h001, 5, 0, 0, 9'h001, 9'h021, 7, 1'b0, 1'b0);

    // Start requests while busy must be ignored.
    start = 1'b1; seed = 9'h001; nsteps = 16'd20;
    @(posedge clk);
    #1;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      start  = (c % 3 == 0) && (c < 20);
      seed   = 9'h055;
      nsteps = 16'd3;
      @(negedge clk);
      if (done) begin
        dones++;
        check("busy_start_result", result, lfsr_run(9'h001, 20));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("busy_start_one_done", dones, 1);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom % 6) == 0;
      hold   = ($urandom % 4) == 0;
      seed   = (($urandom % 5) == 0) ? 9'h000 : W'($urandom);
      nsteps = (($urandom % 20) == 0) ? CW'($urandom % 600) : CW'($urandom % 24);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < 2000 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencer for the 9-bit shift/load register datapath; together they form a run-to-count LFSR engine. On a start request it loads a seed into the register, then issues a programmed number of shift cycles. It computes the serial feedback bit from the register's q. It then returns the final register value with a one-cycle done pulse. It sits between a requesting controller (start/busy/done handshake) and the shift/load register (load, shift, d, d_in, q).

Parameters:
WIDTH, 9, register width; must match the shift/load register.
TAPS, 9'h110, feedback mask; d_in is the XOR of q bits selected by the mask (default q[8]^q[4], polynomial x^9+x^5+1, period 511).
CNT_W, 16, width of the step counter and nsteps.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request pulse or level; sampled only in IDLE.
seed  input  WIDTH  initial register value, captured with start.
nsteps  input  CNT_W  number of shift cycles to run, captured with start.
hold  input  1  pauses shifting while high (RUN state only).
q  input  WIDTH  current register contents, fed back from the register.
load  output  1  register parallel-load enable.
shift  output  1  register shift enable; bit i takes q[i-1], bit 0 takes d_in.
d  output  WIDTH  parallel-load data.
d_in  output  1  serial feedback bit, combinational: ^(q & TAPS).
busy  output  1  high from the cycle after start is accepted until done is pulsed.
done  output  1  one-cycle pulse; result is valid in the same cycle.
result  output  WIDTH  final register value, held until the next done.
zero_seed  output  1  sticky per run; set when seed==0 was replaced by 1.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; load, shift, busy, done and zero_seed are 0; d=0, result=0, counter=0. Reset asserted mid-run aborts immediately; there is no resumption.
- States:
  - IDLE -> LOAD on start.
  - LOAD -> RUN if the captured nsteps != 0, else -> DONE.
  - RUN -> DONE when the counter reaches 0 after the final shift.
  - DONE -> IDLE unconditionally.
- IDLE: on start, register seed_r and cnt=nsteps. If seed==0, seed_r=1 and zero_seed=1; otherwise zero_seed=0. start is ignored in every state other than IDLE.
- LOAD (1 cycle): load=1, d=seed_r, shift=0. The register holds the seed after this edge.
- RUN: shift=!hold, load=0. Each cycle with shift=1 decrements cnt. On the cycle cnt goes 1->0, the next state is DONE.
- DONE (1 cycle): done=1, result<=q (already includes the last shift), busy deasserts on the following edge.
- Latency: start accepted at edge T. done is high in cycle T+2+N+H, where N=nsteps and H=number of hold cycles during RUN. For N=0, done is in cycle T+2 and result=seed_r.
- load and shift are never high in the same cycle; the register's mux priority is never relied upon.
- d is driven with seed_r only in LOAD and is 0 otherwise.
- hold is ignored in IDLE, LOAD and DONE.
- nsteps is modulo 2^CNT_W; a maximum count causes no wrap.

Decomposition:
- Shared package lfsr_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - WIDTH and CNT_W defaults;
  - TAPS_9 = 9'h110;
  - SEED_NONZERO = 9'h001.
- One sub-module, lfsr_step_cnt: a loadable down-counter with decrement enable and a zero flag.
- The FSM and feedback XOR stay in the top module.
- The test top instantiates lfsr_seq_ctrl alongside the shift/load register, with q looped back.

Test Plan:
- Reset low mid-RUN (seed 9'h001, nsteps 100) -> all outputs 0 asynchronously, state IDLE; a new start afterwards runs normally.
- seed 9'h001, nsteps 5, hold 0 -> load pulses in cycle T+1, shift high for 5 cycles, done in cycle T+7, result 9'h021, zero_seed 0.
- seed 9'h0A5, nsteps 0 -> no shift cycles, done in cycle T+2, result 9'h0A5.
- seed 9'h000, nsteps 5 -> d=9'h001 during LOAD, zero_seed=1, result 9'h021.
- seed 9'h001, nsteps 5, hold high for 3 cycles mid-RUN -> shift low during those 3 cycles, done 3 cycles later than without hold (T+10), result 9'h021.
- seed 9'h001, nsteps 511 -> result 9'h001; nsteps 510 -> result != 9'h001. A start pulsed during busy is ignored, with exactly one done per accepted start.
